pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed IF/ID latch: a generic inter-stage pipeline register carrying instruction, PC, exception code and delay-slot flag.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream stall timing is fully registered.
- Provides flush (bubble injection) and a saturating bubble counter for performance analysis.
- Instantiated between every pair of pipeline stages (F/D, D/E, E/M, M/W).

Parameters:
- DATA_W, 32, instruction/payload width
- PC_W, 32, PC field width (carries PC+8 or PC per stage)
- EXC_W, 5, exception/interrupt code width; 0 = no exception
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- flush  in  1  kill all held entries (exception/eret/branch-kill)
- in_valid  in  1  upstream has an entry
- in_ready  out  1  stage can accept an entry
- in_instr  in  DATA_W  instruction word
- in_pc  in  PC_W  PC field
- in_exc  in  EXC_W  exception code raised upstream
- in_bd  in  1  entry is in a branch delay slot
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_instr  out  DATA_W  held instruction (0 when out_valid=0)
- out_pc  out  PC_W  held PC (0 when out_valid=0)
- out_exc  out  EXC_W  held exception code (0 when out_valid=0)
- out_bd  out  1  held delay-slot flag (0 when out_valid=0)
- bubble_cnt  out  CNT_W  cycles with out_ready=1 and out_valid=0

Behaviour:
- Storage: main register M (drives outputs) and skid register S. Each has a valid bit and payload {instr, pc, exc, bd}.
- States:
  - EMPTY: M invalid, S invalid
  - FULL: M valid, S invalid
  - SKID: M valid, S valid
- in_ready = (state != SKID). It is a registered decode, with no combinational path from out_ready.
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. The payload must stay stable while out_valid=1 and out_ready=0.
- Transitions when flush=0:
  - EMPTY: in_fire → FULL (M ← in). Otherwise stay.
  - FULL, in_fire & out_fire → FULL (M ← in).
  - FULL, in_fire & !out_fire → SKID (S ← in, M unchanged).
  - FULL, !in_fire & out_fire → EMPTY.
  - FULL, neither → FULL.
  - SKID, out_fire → FULL (M ← S, S invalidated). in_ready is 0, so no input is taken.
  - SKID, no out_fire → SKID (hold).
- Latency: 1 cycle from in_fire to out_valid when empty; throughput 1 entry/cycle when out_ready=1.
- Flush: next state is EMPTY and all payload registers are zeroed.
  - An entry presented with in_fire in the flush cycle is dropped.
  - An out_fire in the flush cycle still completes; downstream sees the old entry that cycle.
  - in_ready is 1 in the cycle after flush.
- Reset (reset=0 at a clock edge): state EMPTY, all payloads 0, bubble_cnt 0, in_ready 1, out_valid 0.
- Priority: reset > flush > normal. Reset asserted mid-SKID discards both entries.
- Output zeroing: when out_valid=0, out_instr/out_pc/out_exc/out_bd read 0, so a bubble decodes as sll $0,$0,0 with no exception.
- Exception passthrough: in_exc and in_bd travel with their entry unmodified. The stage does not mask or prioritise codes.
- bubble_cnt: +1 on every cycle with out_ready=1 and out_valid=0, saturating at 2^CNT_W−1. Flush does not clear it; only reset does.
- No combinational path from any input to out_* or in_ready.

Decomposition:
- Shared package / header holds:
  - state encodings ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2
  - EXC_NONE = 0
  - default widths
- Natural sub-module: pipe_entry_reg, a single payload+valid register with load/clear. Instantiated twice (M and S).

Test Plan:
- Reset then stream: reset=0 for 2 cycles, then 4 entries instr 0x1,0x2,0x3,0x4 with out_ready=1 → out_valid from cycle after the first in_fire, outputs 0x1..0x4 on consecutive cycles, in_ready stays 1, bubble_cnt stops incrementing once data flows.
- Backpressure/skid: send 0xA then 0xB with out_ready=0 → state SKID, in_ready=0, out_instr holds 0xA. Raise out_ready → 0xA then 0xB, in_ready=1 one cycle after the first out_fire.
- Flush in SKID: hold 0xA/0xB, assert flush with in_valid=1, in_instr=0xC → next cycle out_valid=0, all out_* 0, 0xC never appears, in_ready=1.
- Exception/delay-slot carry: in_exc=5'd8, in_bd=1, in_pc=0x3008 → emerges unchanged with the same entry; following entry has out_exc=0.
- Bubble counter saturation: CNT_W=4, out_ready=1, in_valid=0 for 20 cycles → bubble_cnt reaches 15 and holds. Flush leaves it at 15; reset returns it to 0.
- Reset mid-operation: drive reset=0 while in SKID with out_ready=1 → next cycle EMPTY, out_valid=0, no entry delivered after the reset edge.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// rtl/pipe_stage_skid_pkg.sv - shared state encodings and default widths for pipe_stage_skid
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam int EXC_NONE   = 0;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_PC_W   = 32;
    localparam int DEF_EXC_W  = 5;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - single payload register with valid bit, load and zeroing clear
module pipe_entry_reg #(
    parameter int W = 70
) (
    input  logic         clk_i,
    input  logic         resetn_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Clear wins over load so a kill never lets a new entry slip in; payload is zeroed with the valid bit.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - inter-stage pipeline register with 2-entry skid buffer, flush and bubble counter
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PC_W   = DEF_PC_W,
    parameter int EXC_W  = DEF_EXC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int ENT_W = DATA_W + PC_W + EXC_W + 1;

    state_t             state_q, state_d;
    logic               in_ready_q;
    logic [CNT_W-1:0]   bubble_q, bubble_d;

    logic               m_valid, s_valid;
    logic [ENT_W-1:0]   m_data, s_data, in_data, m_d;
    logic               m_load, m_clear, s_load, s_clear, m_src_s;
    logic               in_fire, out_fire;

    assign in_data  = {in_instr, in_pc, in_exc, in_bd};
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = m_valid & out_ready;
    assign m_d      = m_src_s ? s_data : in_data;

    // Next-state and register-enable decode; flush overrides every normal transition.
    always_comb begin
        state_d = state_q;
        m_load  = 1'b0;
        m_clear = 1'b0;
        s_load  = 1'b0;
        s_clear = 1'b0;
        m_src_s = 1'b0;
        if (flush) begin
            m_clear = 1'b1;
            s_clear = 1'b1;
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        m_load  = 1'b1;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        m_load = 1'b1;
                    end else if (in_fire) begin
                        s_load  = 1'b1;
                        state_d = ST_SKID;
                    end else if (out_fire) begin
                        m_clear = 1'b1;
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire && s_valid) begin
                        m_load  = 1'b1;
                        m_src_s = 1'b1;
                        s_clear = 1'b1;
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    m_clear = 1'b1;
                    s_clear = 1'b1;
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State register; in_ready is decoded from the next state so it leaves as a flop output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_SKID);
        end
    end

    // Saturating count of cycles where downstream was ready but nothing was offered.
    always_comb begin
        bubble_d = bubble_q;
        if (out_ready && !m_valid && !(&bubble_q)) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    // Bubble counter register; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bubble_q <= '0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    pipe_entry_reg #(.W(ENT_W)) u_main (
        .clk_i    (clk),
        .resetn_i (reset),
        .load_i   (m_load),
        .clear_i  (m_clear),
        .data_i   (m_d),
        .valid_o  (m_valid),
        .data_o   (m_data)
    );

    pipe_entry_reg #(.W(ENT_W)) u_skid (
        .clk_i    (clk),
        .resetn_i (reset),
        .load_i   (s_load),
        .clear_i  (s_clear),
        .data_i   (in_data),
        .valid_o  (s_valid),
        .data_o   (s_data)
    );

    // Main register is zeroed whenever it is empty, so outputs read 0 on a bubble with no extra gating.
    assign out_valid  = m_valid;
    assign {out_instr, out_pc, out_exc, out_bd} = m_data;
    assign in_ready   = in_ready_q;
    assign bubble_cnt = bubble_q;

endmodule
